// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment display blocks.
// Segment patterns are active-low {a,b,c,d,e,f,g}, a in bit 6.
package ssd_pkg;

  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [7:0] CATH_OFF  = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Digit i (>0) is a leading zero when it and all higher digits are 0.
  function automatic logic lz_blank(
    input logic [15:0] d,
    input logic [1:0]  i
  );
    logic r;
    r = 1'b0;
    unique case (i)
      2'd1:    r = (d[15:4] == 12'h000);
      2'd2:    r = (d[15:8] == 8'h00);
      2'd3:    r = (d[15:12] == 4'h0);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ssd_seg_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Purely combinational; shared by the display blocks.
module ssd_seg_decode
  import ssd_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Table lookup of the hex glyph.
  always_comb begin
    o_seg = SEG_OFF;
    unique case (i_hex)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// 4-digit multiplexed seven-segment scan controller with
// frame-synchronous shadow update and leading-zero blanking.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          LZ_SUPPRESS  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [15:0] upd_data,
  input  logic [3:0]  upd_dp,
  output logic [3:0]  anode,
  output logic [7:0]  cathode,
  output logic        frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'(BLANK_CYCLES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;

  logic [15:0]   r_act_data;
  logic [3:0]    r_act_dp;
  logic [15:0]   r_shd_data;
  logic [3:0]    r_shd_dp;
  logic          r_pending;

  logic [3:0]    r_anode;
  logic [7:0]    r_cathode;
  logic          r_frame_done;

  state_t        w_nxt_state;
  logic [CW-1:0] w_nxt_cnt;
  logic [1:0]    w_nxt_idx;

  logic          w_boundary;
  logic          w_xfer;
  logic          w_commit;
  logic [15:0]   w_nxt_act_data;
  logic [3:0]    w_nxt_act_dp;

  logic [3:0]    w_nib;
  logic [6:0]    w_seg;
  logic          w_blank;
  logic [3:0]    w_anode_d;
  logic [7:0]    w_cath_d;
  logic          w_fd_d;

  // Last SHOW cycle of digit 3 while scanning.
  assign w_boundary = en
                    & (r_state == ST_SHOW)
                    & (r_idx == 2'd3)
                    & (r_cnt == CNT_LAST);

  assign w_xfer   = upd_valid & ~r_pending;
  // Dark display allows an immediate commit.
  assign w_commit = r_pending & (w_boundary | ~en);

  assign w_nxt_act_data = w_commit ? r_shd_data
                                   : r_act_data;
  assign w_nxt_act_dp   = w_commit ? r_shd_dp
                                   : r_act_dp;

  // Shadow capture and frame-synchronous commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shd_data <= '0;
      r_shd_dp   <= '0;
      r_act_data <= '0;
      r_act_dp   <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_shd_data <= upd_data;
        r_shd_dp   <= upd_dp;
      end
      if (w_commit) begin
        r_act_data <= r_shd_data;
        r_act_dp   <= r_shd_dp;
      end
      r_pending <= w_xfer | (r_pending & ~w_commit);
    end
  end

  // Scan state, slot counter and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_idx   <= w_nxt_idx;
    end
  end

  // Slot sequencing: BLANK then SHOW, then next digit.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt + 1'b1;
    w_nxt_idx   = r_idx;
    if (!en) begin
      w_nxt_state = ST_BLANK;
      w_nxt_cnt   = '0;
      w_nxt_idx   = 2'd0;
    end else begin
      unique case (r_state)
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST)
            w_nxt_state = ST_SHOW;
        end
        ST_SHOW: begin
          if (r_cnt == CNT_LAST) begin
            w_nxt_state = ST_BLANK;
            w_nxt_cnt   = '0;
            w_nxt_idx   = r_idx + 2'd1;
          end
        end
        default: w_nxt_state = ST_BLANK;
      endcase
    end
  end

  assign w_nib = w_nxt_act_data[{w_nxt_idx, 2'b00} +: 4];

  ssd_seg_decode u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  // Pin values for the upcoming cycle.
  always_comb begin
    w_anode_d = ANODE_OFF;
    w_cath_d  = CATH_OFF;
    w_blank   = LZ_SUPPRESS
              && lz_blank(w_nxt_act_data, w_nxt_idx);
    if ((w_nxt_state == ST_SHOW) && !w_blank) begin
      w_anode_d = ~(4'b0001 << w_nxt_idx);
      w_cath_d  = {w_seg, ~w_nxt_act_dp[w_nxt_idx]};
    end
    w_fd_d = (w_nxt_state == ST_SHOW)
          && (w_nxt_idx == 2'd3)
          && (w_nxt_cnt == CNT_LAST);
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_anode      <= ANODE_OFF;
      r_cathode    <= CATH_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_anode      <= w_anode_d;
      r_cathode    <= w_cath_d;
      r_frame_done <= w_fd_d;
    end
  end

  assign upd_ready  = ~r_pending;
  assign anode      = r_anode;
  assign cathode    = r_cathode;
  assign frame_done = r_frame_done;

endmodule
